// File: rtl/uart_tx.sv
// UART transmitter: LSB-first framing on the baud tick, with a one-entry holding register so frames can run back to back.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy
);

  localparam int   CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_txd;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_accept;
  logic                 w_bits_done;
  logic                 w_last_stop;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_txd_next;
  logic [CNT_W-1:0]     w_bit_cnt_next;
  logic                 w_stop_cnt_next;

  assign w_accept    = tx_valid & ~r_hold_full;
  assign w_bits_done = (r_bit_cnt == CNT_W'(DATA_BITS));
  assign w_last_stop = (r_stop_cnt == STOP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: every transition waits for a baud tick
  always_comb begin
    w_state_next = r_state;
    if (baud) begin
      case (r_state)
        S_IDLE:   if (r_hold_full) w_state_next = S_START;
        S_START:  w_state_next = S_DATA;
        S_DATA: begin
          if (w_bits_done) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: w_state_next = S_STOP;
`endif
        S_STOP: begin
          if (w_last_stop) begin
            w_state_next = r_hold_full ? S_START : S_IDLE;
          end
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Output/datapath control: what txd and the counters become at the next edge
  always_comb begin
    w_txd_next      = r_txd;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    if (baud) begin
      case (r_state)
        S_IDLE: begin
          w_txd_next = 1'b1;
          if (r_hold_full) begin
            w_load         = 1'b1;
            w_txd_next     = 1'b0;
            w_bit_cnt_next = '0;
          end
        end
        S_START: begin
          w_txd_next     = r_shift[0];
          w_shift        = 1'b1;
          w_bit_cnt_next = CNT_W'(1);
        end
        S_DATA: begin
          if (w_bits_done) begin
            w_stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_txd_next      = r_parity;
`else
            w_txd_next      = 1'b1;
`endif
          end else begin
            w_txd_next     = r_shift[0];
            w_shift        = 1'b1;
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          w_txd_next      = 1'b1;
          w_stop_cnt_next = 1'b0;
        end
`endif
        S_STOP: begin
          if (w_last_stop) begin
            if (r_hold_full) begin
              // Back-to-back: the next start bit replaces the idle period
              w_load         = 1'b1;
              w_txd_next     = 1'b0;
              w_bit_cnt_next = '0;
            end else begin
              w_txd_next = 1'b1;
            end
          end else begin
            w_txd_next      = 1'b1;
            w_stop_cnt_next = 1'b1;
          end
        end
        default: w_txd_next = 1'b1;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd       <= 1'b1;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
    end else begin
      r_txd      <= w_txd_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      if (w_load) begin
        r_shift <= r_hold;
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
      end
      // A load only happens with holding full and an accept only with it empty
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= (^r_hold) ^ 1'(PARITY_ODD);
    end
  end
`endif

  assign txd      = r_txd;
  assign tx_ready = ~r_hold_full;
  assign tx_busy  = (r_state != S_IDLE) | r_hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8N1 even, 8N2 odd) checked every cycle against a frame-queue model,
// plus literal per-baud-period txd patterns for directed bytes.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud = 1'b0;
  logic [7:0] tx_data [2];
  logic [1:0] tx_valid = 2'b00;
  logic [1:0] tx_ready;
  logic [1:0] txd;
  logic [1:0] tx_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the current frame as a list of line levels, one per baud period
  bit         m_bits [2][16];
  int         m_len  [2];
  int         m_pos  [2];
  bit         m_in_frame [2];
  bit         m_hold_full [2];
  logic [7:0] m_hold [2];
  bit         m_txd [2];

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .baud(baud), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .tx_busy(tx_busy[0])
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst), .baud(baud), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .tx_busy(tx_busy[1])
  );

  initial forever #5 clk = ~clk;

  // Baud tick every 16 clocks; the phase is chosen so a tick lands inside the reset window
  initial begin
    int bcnt;
    bcnt = 14;
    forever begin
      @(posedge clk);
      #1;
      bcnt = (bcnt + 1) % 16;
      baud = (bcnt == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int stops_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic void build_frame(input int k);
    int n;
    m_bits[k][0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[k][1+i] = m_hold[k][i];
    n = 9;
`ifdef UART_TX_PARITY_EN
    m_bits[k][n] = (^m_hold[k]) ^ (k == 1);
    n++;
`endif
    for (int s = 0; s < stops_of(k); s++) begin
      m_bits[k][n] = 1'b1;
      n++;
    end
    m_len[k] = n;
  endfunction

  // Model: each baud tick advances the line by one period; an exhausted frame reloads or idles
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_txd[k] = 1'b1; m_in_frame[k] = 1'b0; m_hold_full[k] = 1'b0;
      m_pos[k] = 0; m_len[k] = 0; m_hold[k] = '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        bit acc;
        if (rst) begin
          m_txd[k] = 1'b1; m_in_frame[k] = 1'b0; m_hold_full[k] = 1'b0; m_pos[k] = 0;
        end else begin
          acc = (tx_valid[k] === 1'b1) && !m_hold_full[k];
          if (baud) begin
            if (m_in_frame[k] && m_pos[k] < m_len[k] - 1) begin
              m_pos[k]++;
              m_txd[k] = m_bits[k][m_pos[k]];
            end else if (m_hold_full[k]) begin
              build_frame(k);
              m_pos[k] = 0;
              m_txd[k] = m_bits[k][0];
              m_in_frame[k] = 1'b1;
              m_hold_full[k] = 1'b0;
            end else begin
              m_in_frame[k] = 1'b0;
              m_txd[k] = 1'b1;
            end
          end
          if (acc) begin
            m_hold[k] = tx_data[k];
            m_hold_full[k] = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare of both instances against the model
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("txd%0d", k),      32'(txd[k]),      32'(m_txd[k]));
      chk($sformatf("tx_ready%0d", k), 32'(tx_ready[k]), 32'(!m_hold_full[k]));
      chk($sformatf("tx_busy%0d", k),  32'(tx_busy[k]),  32'(m_in_frame[k] || m_hold_full[k]));
    end
  end

  function automatic logic [15:0] pat(input string s);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == "1");
    return r;
  endfunction

  task automatic send(input int k, input logic [7:0] d);
    int t;
    t = 0;
    while (tx_ready[k] !== 1'b1 && t < 400) begin
      @(posedge clk); #1; t++;
    end
    chk($sformatf("ready_wait%0d", k), 32'(t >= 400), 32'd0);
    tx_data[k] = d;
    tx_valid[k] = 1'b1;
    @(posedge clk); #1;
    tx_valid[k] = 1'b0;
    tx_data[k] = 8'($urandom);
    $display("send dut%0d byte %02h", k, d);
  endtask

  task automatic wait_fall(input int k);
    int t;
    t = 0;
    while (txd[k] !== 1'b0 && t < 400) begin
      @(negedge clk); t++;
    end
    chk($sformatf("start_wait%0d", k), 32'(t >= 400), 32'd0);
  endtask

  // Samples txd mid-period for n consecutive baud periods, starting at the next start bit
  task automatic capture(input int k, input int n, output logic [15:0] bits);
    bits = '0;
    wait_fall(k);
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bits[i] = txd[k];
      if (i < n - 1) repeat (16) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((tx_busy !== 2'b00) && t < 2000) begin
      @(negedge clk); t++;
    end
    chk("idle_wait", 32'(t >= 2000), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b0;
    logic [15:0] b1;
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;

    // 1. Reset held 3 cycles, one of them with baud high
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_txd",   32'(txd),      32'b11);
    chk("reset_ready", 32'(tx_ready), 32'b11);
    chk("reset_busy",  32'(tx_busy),  32'b00);
    repeat (20) @(negedge clk);

    // 2. 0xA5 on the 8N1 instance
    fork
      capture(0, 11, b0);
      send(0, 8'hA5);
    join
`ifdef UART_TX_PARITY_EN
    chk("frame_a5", 32'(b0), 32'(pat("01010010101")));
`else
    chk("frame_a5", 32'(b0[9:0]), 32'(pat("0101001011")));
`endif
    wait_idle();

    // 3. 0x00 then 0xFF as soon as tx_ready rises: no idle gap between frames
    fork
      capture(0, 12, b0);
      begin
        send(0, 8'h00);
        send(0, 8'hFF);
      end
    join
`ifdef UART_TX_PARITY_EN
    chk("frame_00_ff", 32'(b0), 32'(pat("000000000010")));
`else
    chk("frame_00_ff", 32'(b0[10:0]), 32'(pat("00000000010")));
`endif
    wait_idle();

    // 4. 0x55 then 0x00 on the 8N2 instance: two stop periods before the next start
    fork
      capture(1, 13, b1);
      begin
        send(1, 8'h55);
        send(1, 8'h00);
      end
    join
`ifdef UART_TX_PARITY_EN
    chk("frame_55_2stop", 32'(b1), 32'(pat("0101010101110")));
`else
    chk("frame_55_2stop", 32'(b1[11:0]), 32'(pat("010101010110")));
`endif
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // 5. 0x07 on both instances: even parity 1, odd parity 0
    fork
      capture(0, 11, b0);
      capture(1, 12, b1);
      send(0, 8'h07);
      send(1, 8'h07);
    join
    chk("frame_07_even", 32'(b0), 32'(pat("01110000011")));
    chk("frame_07_odd",  32'(b1), 32'(pat("011100000011")));
    wait_idle();
`endif

    // 6. Reset during data bit 3 of 0x3C with 0x99 held
    send(0, 8'h3C);
    wait_fall(0);
    send(0, 8'h99);
    repeat (66) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_txd",   32'(txd[0]),      32'd1);
    chk("abort_ready", 32'(tx_ready[0]), 32'd1);
    chk("abort_busy",  32'(tx_busy[0]),  32'd0);
    repeat (60) @(negedge clk);
    chk("abort_no_resume", 32'(txd[0]), 32'd1);
    fork
      capture(0, 11, b0);
      send(0, 8'h81);
    join
`ifdef UART_TX_PARITY_EN
    chk("frame_81", 32'(b0), 32'(pat("01000000101")));
`else
    chk("frame_81", 32'(b0[9:0]), 32'(pat("0100000011")));
`endif
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
